sap_out_port: RTL
=================

// Module: sap_out_port
// PURPOSE
//   SAP-1 output port: the read-side counterpart of the D-latch/register storage path.
//   Captures bytes from the W bus when the controller asserts lo.
//   Buffers up to DEPTH bytes in a small FIFO.
//   Delivers them to a slow external consumer (display/host) over a 4-phase valid/ack handshake.
//   Sits between the accumulator-to-W-bus path and the board-level output.
// PARAMETERS
//   WIDTH  8  data width of W bus and output byte
//   DEPTH  4  FIFO entries; power of 2, >= 2
// PORTS
//   clk       in   1              system clock from clock generator; all state on rising edge
//   clr       in   1              asynchronous, active-high reset
//   w_bus     in   WIDTH          W bus data
//   lo        in   1              load strobe: write w_bus into FIFO at rising clk
//   out_data  out  WIDTH          byte presented to consumer; valid only while out_valid=1
//   out_valid out  1              4-phase request
//   out_ack   in   1              4-phase acknowledge (level)
//   full      out  1              count == DEPTH
//   count     out  $clog2(DEPTH)+1  FIFO occupancy
//   overflow  out  1              sticky: a load was dropped
// BEHAVIOUR
//   Reset (clr=1, async): FIFO empty, count=0, full=0, overflow=0, out_valid=0,
//     out_data=0, FSM=IDLE. Reset mid-handshake abandons the current byte.
//   Write: lo=1 and count<DEPTH -> w_bus stored at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//   Drop: lo=1 and full and no pop on the same edge -> byte dropped, overflow<=1.
//     overflow stays set until clr.
//   FSM, 4-phase handshake; all outputs registered:
//     IDLE:    out_valid=0. If count>0 (incl. a write this edge is NOT visible until
//              next edge), then out_data<=head, out_valid<=1, go to SHOW.
//     SHOW:    hold out_data/out_valid. On out_ack=1 -> pop head (rd_ptr++, count--),
//              out_valid<=0, go to RELEASE.
//     RELEASE: out_valid=0. Wait out_ack=0 -> go to IDLE.
//   Latency: lo at edge N into an empty FIFO in IDLE -> out_valid=1 after edge N+1.
//     Minimum 3 cycles per byte with an instant consumer.
//   Simultaneous lo and pop (SHOW with ack=1):
//     count unchanged; when full, the write is accepted (no overflow).
//   out_ack=1 in IDLE is ignored; no pop occurs without SHOW.
//   out_data changes only on the IDLE->SHOW transition; it is stable throughout SHOW.
//   count width: $clog2(DEPTH)+1; never exceeds DEPTH; never underflows.
// CONFIGURATION
//   OUT_PORT_HOLD_EN defined:
//     adds output port hold_data [WIDTH-1:0], reset 0.
//     Loads the popped byte on the SHOW->RELEASE edge; persists until the next pop.
//     Drives a static LED display.
//   OUT_PORT_HOLD_EN undefined:
//     no hold_data port and no hold register; all other behaviour identical.
// TESTING
//   1. clr pulse mid-SHOW with FIFO holding 2 bytes -> out_valid=0, count=0,
//      overflow=0 immediately (async), FSM IDLE.
//   2. lo with w_bus=8'hA5 on an idle port; ack at first out_valid, dropped next cycle
//      -> out_data=A5 with out_valid=1 two edges after the load.
//      Then after the ack edge count=0 and out_valid=0.
//   3. Load 8'h01,02,03,04 on back-to-back edges with ack=0 -> full=1, count=4.
//      Fifth load 8'h05 -> dropped, overflow=1, count stays 4.
//   4. Full FIFO in SHOW: lo=1 (8'h06) and ack=1 on the same edge
//      -> count stays 4, overflow unchanged, 06 delivered last.
//      Delivery order is 01,02,03,04,06.
//   5. Hold out_ack=1 for 5 cycles after a pop -> FSM stays in RELEASE and
//      out_valid stays 0 until ack falls; exactly one byte consumed.
//   6. OUT_PORT_HOLD_EN defined: deliver 8'h3C then 8'hC3
//      -> hold_data=3C after first ack, C3 after second; 00 after clr.

Source files
------------

// File: rtl/sap_out_port.sv
// SAP-1 output port: captures W-bus bytes on lo into a small FIFO and delivers them over a 4-phase valid/ack handshake.
// Optional feature macro OUT_PORT_HOLD_EN adds a hold_data register holding the last consumed byte.
module sap_out_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           w_bus,
    input  logic                       lo,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
`ifdef OUT_PORT_HOLD_EN
    ,
    output logic [WIDTH-1:0]           hold_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SHOW    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              valid_next;
    logic              load_out;
    logic              pop;
    logic              push;
    logic              drop;
    logic [CW-1:0]     count_next;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Handshake FSM next-state and output decisions
    always_comb begin
        state_next = state;
        valid_next = out_valid;
        load_out   = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                // A write on this same edge is not yet reflected in count
                if (count != {CW{1'b0}}) begin
                    load_out   = 1'b1;
                    valid_next = 1'b1;
                    state_next = SHOW;
                end else begin
                    valid_next = 1'b0;
                end
            end
            SHOW: begin
                if (out_ack) begin
                    pop        = 1'b1;
                    valid_next = 1'b0;
                    state_next = RELEASE;
                end else begin
                    valid_next = 1'b1;
                end
            end
            RELEASE: begin
                if (!out_ack) begin
                    state_next = IDLE;
                end else begin
                    state_next = RELEASE;
                end
                valid_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // FIFO write/drop decisions and occupancy update
    always_comb begin
        push       = lo && ((count != DEPTH_C) || pop);
        drop       = lo && (count == DEPTH_C) && !pop;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FSM state and registered handshake outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
            if (load_out) begin
                out_data <= mem[rd_ptr];
            end else begin
                out_data <= out_data;
            end
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {WIDTH{1'b0}};
            end
            wr_ptr   <= {AW{1'b0}};
            rd_ptr   <= {AW{1'b0}};
            count    <= {CW{1'b0}};
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // When full, a simultaneous pop frees the slot being overwritten
            if (push) begin
                mem[wr_ptr] <= w_bus;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef OUT_PORT_HOLD_EN
    // Latch the consumed byte for a static display
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold_data <= {WIDTH{1'b0}};
        end else if (pop) begin
            hold_data <= out_data;
        end else begin
            hold_data <= hold_data;
        end
    end
`endif

endmodule
